// File: rtl/decoder_bbm_pkg.sv
// Shared types and helpers for the break-before-make one-hot decoder.
package decoder_pkg;

    // Widest one-hot vector the helpers can produce (SEL_W up to 8).
    localparam int MAX_OUT_W = 256;

    // IDLE: nothing driven, ready for a new select.
    // DEAD: forced all-zero gap between two hot lines.
    // DRIVE: the latched select is hot.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // One-hot of idx within a vector of the given width; all-zero when idx
    // falls outside that width, so callers can OR-reduce it as a range test.
    function automatic logic [MAX_OUT_W-1:0] onehot(input int idx, input int width);
        logic [MAX_OUT_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (idx >= 0 && idx < width && idx < MAX_OUT_W) begin
            return one << idx;
        end
        return '0;
    endfunction

    // Counter width able to hold the longer of the dead and pulse lengths,
    // never narrower than one bit.
    function automatic int cnt_w(input int dead_cyc, input int pulse_cyc);
        int longest;
        longest = (dead_cyc > pulse_cyc) ? dead_cyc : pulse_cyc;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/decoder_bbm_if.sv
// Request and output bundle of the break-before-make decoder.
//
// Handshake: a request transfers on a rising clk edge where en, in_valid and
// in_ready are all high. in_ready is combinational from the decoder state and
// en only (never from in_valid), so the master may make in_valid depend on
// in_ready without creating a loop. in_sel must be stable while in_valid is
// high; a request not taken on an edge may be dropped or changed freely.
interface decoder_bbm_if #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
);
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [OUT_W-1:0] out;
    logic             out_active;
    logic             err;

    modport master (
        output en,
        output in_valid,
        output in_sel,
        input  in_ready,
        input  out,
        input  out_active,
        input  err
    );

    modport slave (
        input  en,
        input  in_valid,
        input  in_sel,
        output in_ready,
        output out,
        output out_active,
        output err
    );
endinterface

// File: rtl/decoder_bbm_onehot_dec.sv
// Combinational binary-to-one-hot decode with an in-range flag.
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] hot,
    output logic             valid
);

    logic [MAX_OUT_W-1:0] hot_full;

    // Decode; an out-of-range index yields no bit at all, which is the range flag.
    always_comb begin
        hot_full = onehot(int'(sel), OUT_W);
        hot      = hot_full[OUT_W-1:0];
        valid    = |hot_full;
    end

endmodule

// File: rtl/decoder_bbm.sv
// Registered one-hot decoder with break-before-make dead time and an optional
// fixed-length pulse mode. Output never jumps directly between two hot lines
// unless the dead time is configured as zero in level mode.
module decoder_bbm
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int OUT_W     = 8,
    parameter int DEAD_CYC  = 1,
    parameter int PULSE_CYC = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    decoder_bbm_if.slave bus,
    output state_t       dbg_state
);

    localparam int CNT_W      = cnt_w(DEAD_CYC, PULSE_CYC);
    localparam bit PULSE_MODE = (PULSE_CYC > 0);
    localparam bit HAS_DEAD   = (DEAD_CYC > 0);

    // Counters load N-1 on entry and leave at zero, giving exactly N cycles.
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(HAS_DEAD ? DEAD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_MODE ? PULSE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    if (SEL_W < 1 || SEL_W > 8) begin : g_chk_sel_w
        $error("decoder_bbm: SEL_W must be in 1..8");
    end
    if (OUT_W < 2 || OUT_W > (1 << SEL_W)) begin : g_chk_out_w
        $error("decoder_bbm: OUT_W must be in 2..2**SEL_W");
    end
    if (DEAD_CYC < 0 || DEAD_CYC > 255) begin : g_chk_dead
        $error("decoder_bbm: DEAD_CYC must be in 0..255");
    end
    if (PULSE_CYC < 0 || PULSE_CYC > 255) begin : g_chk_pulse
        $error("decoder_bbm: PULSE_CYC must be in 0..255");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] dec_sel;
    logic [OUT_W-1:0] dec_hot;
    logic             dec_ok;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;
    logic             active_q;
    logic             err_q;
    logic             err_d;
    logic             ready;
    logic             accept;
    logic             take;

    // Ready only where a request can change the plan: IDLE, or a held level;
    // dropping en masks it regardless of state.
    always_comb begin
        ready  = bus.en & ((state_q == IDLE) | ((state_q == DRIVE) & ~PULSE_MODE));
        accept = bus.in_valid & ready;
    end

    // One decoder serves both the incoming request and the held select: a
    // request is decoded on its accept edge, otherwise the latched select is.
    always_comb begin
        dec_sel = accept ? bus.in_sel : sel_q;
        take    = accept & dec_ok;
    end

    onehot_dec #(
        .SEL_W(SEL_W),
        .OUT_W(OUT_W)
    ) u_dec (
        .sel  (dec_sel),
        .hot  (dec_hot),
        .valid(dec_ok)
    );

    // Next state, counter, latched select and error pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        err_d   = accept & ~dec_ok;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        sel_d   = bus.in_sel;
                        state_d = DRIVE;
                        cnt_d   = PULSE_MODE ? PULSE_LOAD : '0;
                    end
                end
                DRIVE: begin
                    if (PULSE_MODE) begin
                        if (cnt_q == '0) begin
                            state_d = HAS_DEAD ? DEAD : IDLE;
                            cnt_d   = HAS_DEAD ? DEAD_LOAD : '0;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end else if (take && (bus.in_sel != sel_q)) begin
                        sel_d = bus.in_sel;
                        if (HAS_DEAD) begin
                            state_d = DEAD;
                            cnt_d   = DEAD_LOAD;
                        end
                    end
                end
                DEAD: begin
                    if (cnt_q == '0) begin
                        state_d = PULSE_MODE ? IDLE : DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Next output: hot only in DRIVE; a rejected select keeps the current line.
    always_comb begin
        out_d = '0;
        if (state_d == DRIVE) begin
            out_d = (accept && !dec_ok) ? out_q : dec_hot;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            out_q    <= '0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            out_q    <= out_d;
            active_q <= |out_d;
            err_q    <= err_d;
        end
    end

    // Drive the bundle and the debug state.
    always_comb begin
        bus.in_ready   = ready;
        bus.out        = out_q;
        bus.out_active = active_q;
        bus.err        = err_q;
        dbg_state      = state_q;
    end

endmodule
